// File: rtl/dac_frame_ctrl.sv
// Frame controller: serializes parallel DAC codes (start bit + MSB-first data) for the thermometer decoder.
// Optional even-parity bit after the data is enabled by defining DAC_FRAME_PARITY_EN.
module dac_frame_ctrl #(
    parameter int D_W     = 8,
    parameter int CLK_DIV = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [D_W-1:0] code_in,
    input  logic           code_valid,
    output logic           code_ready,
    output logic           serial_out,
    output logic           frame_busy,
    output logic           update_strobe,
    output logic [D_W-1:0] last_code
);

    localparam int         CNT_W    = (D_W > 1) ? $clog2(D_W) : 1;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

`ifdef DAC_FRAME_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_PARITY = 3'd3,
        ST_LATCH  = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [D_W-1:0] v);
        return ^v;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd4
    } state_t;
`endif

    state_t           r_state;
    logic [7:0]       r_div;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [D_W-1:0]   r_shift;
    logic [D_W-1:0]   r_code;
    logic             r_ready;
    logic             r_serial;
    logic             r_busy;
    logic             r_strobe;
    logic [D_W-1:0]   r_last;

    state_t           w_state_nxt;
    logic [7:0]       w_div_nxt;
    logic [CNT_W-1:0] w_bit_nxt;
    logic [D_W-1:0]   w_shift_nxt;
    logic [D_W-1:0]   w_code_nxt;
    logic             w_tick;
    logic             w_serial_nxt;

    assign w_tick = (r_div == DIV_LAST);

    // Next-state, shift register, bit counter and divider update
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_code_nxt  = r_code;
        case (r_state)
            ST_IDLE: begin
                if (code_valid && r_ready) begin
                    w_shift_nxt = code_in;
                    w_code_nxt  = code_in;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift << 1;
                    if (r_bit_cnt == CNT_W'(D_W - 1)) begin
                        w_bit_nxt   = '0;
`ifdef DAC_FRAME_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_LATCH;
`endif
                    end else begin
                        w_bit_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
`ifdef DAC_FRAME_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_LATCH;
                end else begin
                    w_state_nxt = ST_PARITY;
                end
            end
`endif
            ST_LATCH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // divider restarts on every bit boundary and on every state change
        if (w_tick || (w_state_nxt != r_state)) begin
            w_div_nxt = 8'd0;
        end else begin
            w_div_nxt = r_div + 8'd1;
        end
    end

    // Serial line value for the upcoming cycle, so serial_out can be registered
    always_comb begin
        w_serial_nxt = 1'b0;
        case (w_state_nxt)
            ST_START:  w_serial_nxt = 1'b1;
            ST_SHIFT:  w_serial_nxt = w_shift_nxt[D_W-1];
`ifdef DAC_FRAME_PARITY_EN
            ST_PARITY: w_serial_nxt = even_parity(w_code_nxt);
`endif
            default:   w_serial_nxt = 1'b0;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_div     <= 8'd0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_code    <= '0;
            r_ready   <= 1'b0;
            r_serial  <= 1'b0;
            r_busy    <= 1'b0;
            r_strobe  <= 1'b0;
            r_last    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_code    <= w_code_nxt;
            r_ready   <= (w_state_nxt == ST_IDLE);
            r_serial  <= w_serial_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_strobe  <= (w_state_nxt == ST_LATCH);
            if (w_state_nxt == ST_LATCH) begin
                r_last <= w_code_nxt;
            end else begin
                r_last <= r_last;
            end
        end
    end

    assign code_ready    = r_ready;
    assign serial_out    = r_serial;
    assign frame_busy    = r_busy;
    assign update_strobe = r_strobe;
    assign last_code     = r_last;

endmodule

// File: tb/tb_dac_frame_ctrl.sv
// Directed bench for dac_frame_ctrl: one instance with CLK_DIV=1, one with CLK_DIV=3.
module tb_dac_frame_ctrl;

`ifdef DAC_FRAME_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] code_in;
    logic [1:0] cv;
    logic [1:0] cr, so, busy, stb;
    logic [7:0] lc0, lc1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_a, t_b;

    always #5 clk = ~clk;

    dac_frame_ctrl #(.D_W(8), .CLK_DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(cv[0]),
        .code_ready(cr[0]), .serial_out(so[0]), .frame_busy(busy[0]),
        .update_strobe(stb[0]), .last_code(lc0)
    );

    dac_frame_ctrl #(.D_W(8), .CLK_DIV(3)) u_div3 (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(cv[1]),
        .code_ready(cr[1]), .serial_out(so[1]), .frame_busy(busy[1]),
        .update_strobe(stb[1]), .last_code(lc1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // expected line value in cycle c (1 = first cycle after accept) for frame bits only
    function automatic logic exp_bit(input logic [7:0] code, input int div, input int c);
        int idx;
        idx = (c - 1) / div;
        if (idx == 0) return 1'b1;
        if (idx <= 8) return code[8 - idx];
        if (idx == 9 && P == 1) return ^code;
        return 1'b0;
    endfunction

    task automatic run_frame(input logic [7:0] code, input int sel, input bit hold,
                             output int strobe_cyc);
        int div;
        int s;
        logic [7:0] lc;
        div = (sel == 0) ? 1 : 3;
        s   = 1 + (9 + P) * div;
        strobe_cyc = -1;
        code_in = code;
        cv[sel] = 1'b1;
        step();
        if (!hold) cv[sel] = 1'b0;
        for (int c = 1; c <= s + 1; c++) begin
            lc = (sel == 0) ? lc0 : lc1;
            if (c < s)
                check($sformatf("ser_%0h_d%0d_c%0d", code, div, c), 32'(so[sel]), 32'(exp_bit(code, div, c)));
            else
                check($sformatf("ser_%0h_d%0d_c%0d", code, div, c), 32'(so[sel]), 32'd0);
            check($sformatf("stb_%0h_d%0d_c%0d", code, div, c), 32'(stb[sel]), 32'(c == s));
            check($sformatf("busy_%0h_d%0d_c%0d", code, div, c), 32'(busy[sel]), 32'(c <= s));
            check($sformatf("rdy_%0h_d%0d_c%0d", code, div, c), 32'(cr[sel]), 32'(c == s + 1));
            if (c == s) begin
                check($sformatf("last_%0h_d%0d", code, div), 32'(lc), 32'(code));
                if (stb[sel]) strobe_cyc = cyc;
            end
            if (c != s + 1) step();
        end
    endtask

    initial begin
        rst     = 1'b1;
        cv      = 2'b00;
        code_in = 8'h00;

        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_ser_%0d", i), 32'(so), 32'd0);
            check($sformatf("rst_rdy_%0d", i), 32'(cr), 32'd0);
            check($sformatf("rst_busy_%0d", i), 32'(busy), 32'd0);
            check($sformatf("rst_stb_%0d", i), 32'(stb), 32'd0);
            check($sformatf("rst_last_%0d", i), {16'd0, lc0, lc1}, 32'd0);
        end
        rst = 1'b0;
        step();
        check("rel_rdy", 32'(cr), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("idle_ser_%0d", i), 32'(so), 32'd0);
            check($sformatf("idle_busy_%0d", i), 32'(busy), 32'd0);
        end

        run_frame(8'hA5, 0, 1'b0, t_a);
        check("a5_strobe_seen", 32'(t_a >= 0), 32'd1);

        run_frame(8'h81, 1, 1'b0, t_a);
        check("81_strobe_seen", 32'(t_a >= 0), 32'd1);

        run_frame(8'h00, 0, 1'b1, t_a);
        run_frame(8'hFF, 0, 1'b0, t_b);
        check("b2b_gap", 32'(t_b - t_a), 32'(9 + P + 2));

        code_in = 8'h3C;
        cv[0]   = 1'b1;
        step();
        cv[0] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("abort_ser_c%0d", c), 32'(so[0]), 32'(exp_bit(8'h3C, 1, c)));
            if (c != 5) step();
        end
        rst = 1'b1;
        step();
        check("abort_ser", 32'(so[0]), 32'd0);
        check("abort_last", 32'(lc0), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_stb", 32'(stb[0]), 32'd0);
        rst = 1'b0;
        step();
        check("abort_rdy", 32'(cr[0]), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("abort_nostb_%0d", i), 32'(stb[0]), 32'd0);
            check($sformatf("abort_idle_last_%0d", i), 32'(lc0), 32'd0);
        end
        run_frame(8'h3C, 0, 1'b0, t_a);

`ifdef DAC_FRAME_PARITY_EN
        run_frame(8'h07, 0, 1'b0, t_a);
        run_frame(8'h03, 0, 1'b0, t_a);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_frame_ctrl.md
Name: dac_frame_ctrl

Overview:
Frame controller that sequences the serial thermometer decoder in the R2R DAC path. It accepts parallel DAC codes over a valid/ready handshake and serializes each into a framed bit stream on serial_out, which drives the decoder's serial_in. One-cycle update_strobe marks frame completion. Sits between the sample source (test pattern / host register) and the decoder.

Parameters:
- D_W, 8: code width in bits; must match the decoder's D_W.
- CLK_DIV, 1: clk cycles per serial bit; legal range 1..255.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- code_in  input  D_W  DAC code to send; sampled on handshake.
- code_valid  input  1  requester has a code.
- code_ready  output  1  controller can accept a code (IDLE only).
- serial_out  output  1  framed serial stream to decoder serial_in.
- frame_busy  output  1  high from accept through the strobe cycle.
- update_strobe  output  1  one-cycle pulse after the last frame bit.
- last_code  output  D_W  most recently completed code.

Behaviour:
- Reset: sync, active-high; rst wins over every other event.
  - While rst is high: serial_out=0, code_ready=0, frame_busy=0, update_strobe=0, last_code=0, state=IDLE.
- Frame format:
  - Start bit '1', then D_W data bits MSB-first.
  - Then a parity bit if the optional feature is enabled.
  - Each bit is held exactly CLK_DIV cycles.
- FSM states: IDLE, START, SHIFT, LATCH.
- IDLE:
  - code_ready=1, serial_out=0.
  - On code_valid & code_ready: capture code_in into the shift register and go to START.
  - code_in is don't-care outside the handshake.
- START: serial_out=1 for CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - serial_out = shift-register MSB.
  - Every CLK_DIV cycles, shift left by 1 and increment the bit counter (0..D_W-1).
  - After bit D_W-1 completes: go to PARITY (feature enabled) or LATCH.
- LATCH:
  - Exactly 1 cycle: serial_out=0, update_strobe=1, last_code = captured code.
  - Then IDLE.
- Divider: a counter counts 0..CLK_DIV-1 and clears on every state change. With CLK_DIV=1 there is no idle cycle between bits.
- Latency, with the accept edge at cycle 0 (CLK_DIV=1, D_W=8, no parity):
  - Start bit in cycle 1.
  - Data bits in cycles 2..9.
  - update_strobe in cycle 10.
  - code_ready=1 again in cycle 11.
  - General strobe cycle: 1+(1+D_W+P)*CLK_DIV, where P=1 if parity is enabled.
- frame_busy = (state != IDLE).
- Back-to-back codes: a code held valid across frames is accepted in the first IDLE cycle. Minimum frame period is (1+D_W+P)*CLK_DIV + 2 cycles.
- code_valid asserted during a frame is ignored, since code_ready=0. The requester must hold it until accepted.
- rst mid-frame: the frame is aborted, no update_strobe is issued, last_code is cleared to 0, and the next cycle after rst deasserts is IDLE.
- Codes 0 and all-ones need no special cases; every frame has the same length.

Optional Feature:
- Macro: DAC_FRAME_PARITY_EN.
- Defined:
  - Adds state PARITY after SHIFT.
  - serial_out = even parity (XOR of all D_W code bits) for CLK_DIV cycles, then LATCH.
  - P=1 in all timing formulas.
- Undefined: PARITY state and parity logic are absent; SHIFT goes directly to LATCH; P=0.

Test Plan:
- Reset/idle: hold rst=1 for 3 cycles, then release -> all outputs 0 during rst; code_ready=1 the first cycle after release; serial_out stays 0 with no valid.
- Single frame (CLK_DIV=1): code_in=8'hA5 accepted at cycle 0 -> serial_out cycles 1..9 = 1,1,0,1,0,0,1,0,1; update_strobe=1 only in cycle 10; last_code=8'hA5; code_ready=1 in cycle 11.
- Bit stretching (CLK_DIV=3): code 8'h81 -> start bit held 3 cycles; each data bit held 3 cycles; strobe in cycle 28.
- Back-to-back: code_valid held high with 8'h00 then 8'hFF -> second accept in the first IDLE cycle after the first strobe; 0x00 frame = 1 then eight 0s; 0xFF frame = nine 1s; two strobes 11 cycles apart.
- Reset mid-frame: rst=1 at cycle 5 of an 8'h3C frame -> no strobe; serial_out=0 and last_code=0 from the next cycle; a fresh 8'h3C after release completes normally.
- Parity (DAC_FRAME_PARITY_EN defined, CLK_DIV=1): 8'h07 -> parity bit=1 in cycle 10, strobe in cycle 11; 8'h03 -> parity bit=0.
